fifo_flags: RTL and testbench

//  Parametrised synchronous single-clock FIFO, successor to the basic fifo block.

---
 rtl/fifo_flags.sv | 170 +++++++++++++++++
 tb/tb_fifo_flags.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_flags.sv
`default_nettype none
// ============================================================================
// Module      : fifo_flags
// Description : Single-clock synchronous FIFO with arbitrary depth, occupancy
//               count, almost-full/almost-empty thresholds, sticky
//               overflow/underflow flags, synchronous flush and a selectable
//               standard or first-word-fall-through read port.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_flags #(
    parameter int DATA_W    = 8,
    parameter int L         = 8,
    parameter int AF_THRESH = L - 1,
    parameter int AE_THRESH = 1,
    parameter int FWFT      = 0,
    parameter int ADD_W     = $clog2(L),
    parameter int CNT_W     = $clog2(L + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);

    // Highest storage address; pointers wrap from here back to zero so the
    // depth need not be a power of two.
    localparam logic [ADD_W-1:0] c_LAST_ADDR = ADD_W'(L - 1);
    localparam logic [CNT_W-1:0] c_DEPTH     = CNT_W'(L);
    localparam logic [CNT_W-1:0] c_AF_LEVEL  = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] c_AE_LEVEL  = CNT_W'(AE_THRESH);

    // Storage array (deliberately not reset)
    logic [DATA_W-1:0] r_mem [L];

    // Registered state
    logic [ADD_W-1:0]  r_wr_ptr;
    logic [ADD_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              r_underflow;

    // Combinational helpers
    logic              w_empty;
    logic              w_full;
    logic              w_rd_ok;
    logic              w_wr_ok;
    logic [ADD_W-1:0]  w_wr_ptr_nxt;
    logic [ADD_W-1:0]  w_rd_ptr_nxt;
    logic [CNT_W-1:0]  w_count_nxt;

    // Status decoded purely from the registered count, so no request input
    // ever reaches a status output combinationally.
    always_comb begin
        w_empty = (r_count == '0);
        w_full  = (r_count == c_DEPTH);
    end

    // Accept decisions: a read frees a slot, so a full FIFO still takes a
    // write when a read is accepted on the same edge.
    always_comb begin
        w_rd_ok = rd_en & ~w_empty;
        w_wr_ok = wr_en & (~w_full | w_rd_ok);
    end

    // Pointer advance with explicit wrap at the last address.
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        if (w_wr_ok) begin
            w_wr_ptr_nxt = (r_wr_ptr == c_LAST_ADDR) ? '0 : r_wr_ptr + 1'b1;
        end
        if (w_rd_ok) begin
            w_rd_ptr_nxt = (r_rd_ptr == c_LAST_ADDR) ? '0 : r_rd_ptr + 1'b1;
        end
    end

    // Occupancy moves only when exactly one side is accepted.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_ok, w_rd_ok})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointer, count and sticky error registers; flush wins over requests.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clr) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_count     <= w_count_nxt;
            if (wr_en && !w_wr_ok) begin
                r_overflow <= 1'b1;
            end
            if (rd_en && !w_rd_ok) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Storage write; a flush cycle drops the incoming word.
    always_ff @(posedge clk) begin
        if (!clr && w_wr_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented continuously; zero while nothing is stored.
            always_comb begin
                dout = w_empty ? '0 : r_mem[r_rd_ptr];
            end
        end else begin : g_std
            logic [DATA_W-1:0] r_dout;

            // Registered read port: loads on an accepted read, holds otherwise.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_dout <= '0;
                end else if (clr) begin
                    r_dout <= '0;
                end else if (w_rd_ok) begin
                    r_dout <= r_mem[r_rd_ptr];
                end
            end

            // Drive the data output from the read register.
            always_comb begin
                dout = r_dout;
            end
        end
    endgenerate

    // Output mapping of status and counters.
    always_comb begin
        full         = w_full;
        empty        = w_empty;
        almost_full  = (r_count >= c_AF_LEVEL);
        almost_empty = (r_count <= c_AE_LEVEL);
        count        = r_count;
        overflow     = r_overflow;
        underflow    = r_underflow;
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_flags.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_flags
// Description : Self-checking bench for fifo_flags. Two instances (standard
//               read L=3, FWFT L=8 AF=6) are compared every cycle against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_flags;

    localparam int DW  = 8;
    localparam int LA  = 3;
    localparam int AFA = LA - 1;
    localparam int AEA = 1;
    localparam int LB  = 8;
    localparam int AFB = 6;
    localparam int AEB = 1;
    localparam int CA  = $clog2(LA + 1);
    localparam int CB  = $clog2(LB + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic          a_clr, a_wr, a_rd;
    logic [DW-1:0] a_din;
    logic [DW-1:0] a_dout;
    logic          a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic [CA-1:0] a_count;

    logic          b_clr, b_wr, b_rd;
    logic [DW-1:0] b_din;
    logic [DW-1:0] b_dout;
    logic          b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [CB-1:0] b_count;

    fifo_flags #(.DATA_W(DW), .L(LA), .FWFT(0)) u_a (
        .clk(clk), .rst(rst), .clr(a_clr), .wr_en(a_wr), .din(a_din),
        .rd_en(a_rd), .dout(a_dout), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae), .count(a_count),
        .overflow(a_ovf), .underflow(a_unf)
    );

    fifo_flags #(.DATA_W(DW), .L(LB), .AF_THRESH(AFB), .FWFT(1)) u_b (
        .clk(clk), .rst(rst), .clr(b_clr), .wr_en(b_wr), .din(b_din),
        .rd_en(b_rd), .dout(b_dout), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
        .overflow(b_ovf), .underflow(b_unf)
    );

    // Reference model state
    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    bit            ovfa, unfa, ovfb, unfb;
    logic [DW-1:0] douta;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        qa.delete(); qb.delete();
        ovfa = 0; unfa = 0; ovfb = 0; unfb = 0;
        douta = '0;
    endtask

    // One clock edge of the standard-read FIFO as seen from the outside.
    task automatic model_a();
        bit rok, wok;
        if (!rst) begin
            qa.delete(); ovfa = 0; unfa = 0; douta = '0;
        end else if (a_clr) begin
            qa.delete(); ovfa = 0; unfa = 0; douta = '0;
        end else begin
            rok = a_rd && (qa.size() > 0);
            wok = a_wr && ((qa.size() < LA) || rok);
            if (rok) douta = qa.pop_front();
            if (wok) qa.push_back(a_din);
            if (a_wr && !wok) ovfa = 1;
            if (a_rd && !rok) unfa = 1;
        end
    endtask

    // One clock edge of the FWFT FIFO; the shown word is simply the queue head.
    task automatic model_b();
        bit rok, wok;
        if (!rst || b_clr) begin
            qb.delete(); ovfb = 0; unfb = 0;
        end else begin
            rok = b_rd && (qb.size() > 0);
            wok = b_wr && ((qb.size() < LB) || rok);
            if (rok) void'(qb.pop_front());
            if (wok) qb.push_back(b_din);
            if (b_wr && !wok) ovfb = 1;
            if (b_rd && !rok) unfb = 1;
        end
    endtask

    task automatic check_a();
        chk("a.count", 32'(a_count), 32'(qa.size()));
        chk("a.empty", 32'(a_empty), 32'(qa.size() == 0));
        chk("a.full",  32'(a_full),  32'(qa.size() == LA));
        chk("a.afull", 32'(a_af),    32'(qa.size() >= AFA));
        chk("a.aempty",32'(a_ae),    32'(qa.size() <= AEA));
        chk("a.ovf",   32'(a_ovf),   32'(ovfa));
        chk("a.unf",   32'(a_unf),   32'(unfa));
        chk("a.dout",  32'(a_dout),  32'(douta));
    endtask

    task automatic check_b();
        logic [DW-1:0] head;
        head = (qb.size() > 0) ? qb[0] : '0;
        chk("b.count", 32'(b_count), 32'(qb.size()));
        chk("b.empty", 32'(b_empty), 32'(qb.size() == 0));
        chk("b.full",  32'(b_full),  32'(qb.size() == LB));
        chk("b.afull", 32'(b_af),    32'(qb.size() >= AFB));
        chk("b.aempty",32'(b_ae),    32'(qb.size() <= AEB));
        chk("b.ovf",   32'(b_ovf),   32'(ovfb));
        chk("b.unf",   32'(b_unf),   32'(unfb));
        chk("b.dout",  32'(b_dout),  32'(head));
    endtask

    // Advance one edge, update both models, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_a();
        model_b();
        #1;
        check_a();
        check_b();
    endtask

    task automatic a_op(input bit w, input bit r, input bit c, input logic [DW-1:0] d);
        a_wr = w; a_rd = r; a_clr = c; a_din = d;
        tick();
        a_wr = 0; a_rd = 0; a_clr = 0;
    endtask

    task automatic b_op(input bit w, input bit r, input bit c, input logic [DW-1:0] d);
        b_wr = w; b_rd = r; b_clr = c; b_din = d;
        tick();
        b_wr = 0; b_rd = 0; b_clr = 0;
    endtask

    initial begin
        rst = 1'b0;
        a_clr = 0; a_wr = 0; a_rd = 0; a_din = '0;
        b_clr = 0; b_wr = 0; b_rd = 0; b_din = '0;
        model_reset();

        // Reset values
        #12;
        check_a();
        check_b();
        chk("rst.a.aempty", 32'(a_ae), 32'd1);
        chk("rst.b.dout",   32'(b_dout), 32'd0);
        rst = 1'b1;

        // Fill / drain, standard read
        a_op(1, 0, 0, 8'd3);
        a_op(1, 0, 0, 8'd4);
        a_op(1, 0, 0, 8'd5);
        chk("fill.full",  32'(a_full),  32'd1);
        chk("fill.count", 32'(a_count), 32'd3);
        a_op(0, 1, 0, 8'd0); chk("drain.d0", 32'(a_dout), 32'd3);
        a_op(0, 1, 0, 8'd0); chk("drain.d1", 32'(a_dout), 32'd4);
        a_op(0, 1, 0, 8'd0); chk("drain.d2", 32'(a_dout), 32'd5);
        chk("drain.empty", 32'(a_empty), 32'd1);
        a_op(0, 0, 0, 8'd0); chk("hold.dout", 32'(a_dout), 32'd5);

        // Pointer wrap
        a_op(1, 0, 0, 8'd3); a_op(1, 0, 0, 8'd4); a_op(1, 0, 0, 8'd5);
        a_op(0, 1, 0, 8'd0); a_op(0, 1, 0, 8'd0);
        a_op(1, 0, 0, 8'd6); a_op(1, 0, 0, 8'd7);
        chk("wrap.count", 32'(a_count), 32'd3);
        a_op(0, 1, 0, 8'd0); chk("wrap.d0", 32'(a_dout), 32'd5);
        a_op(0, 1, 0, 8'd0); chk("wrap.d1", 32'(a_dout), 32'd6);
        a_op(0, 1, 0, 8'd0); chk("wrap.d2", 32'(a_dout), 32'd7);

        // Overflow, underflow, flush
        a_op(1, 0, 0, 8'd3); a_op(1, 0, 0, 8'd4); a_op(1, 0, 0, 8'd5);
        a_op(1, 0, 0, 8'd8);
        chk("ovf.flag",  32'(a_ovf),   32'd1);
        chk("ovf.count", 32'(a_count), 32'd3);
        a_op(0, 1, 0, 8'd0); chk("ovf.d0", 32'(a_dout), 32'd3);
        a_op(0, 1, 0, 8'd0); chk("ovf.d1", 32'(a_dout), 32'd4);
        a_op(0, 1, 0, 8'd0); chk("ovf.d2", 32'(a_dout), 32'd5);
        a_op(0, 1, 0, 8'd0);
        chk("unf.flag", 32'(a_unf), 32'd1);
        a_op(1, 1, 1, 8'd9);
        chk("clr.ovf",   32'(a_ovf),   32'd0);
        chk("clr.unf",   32'(a_unf),   32'd0);
        chk("clr.count", 32'(a_count), 32'd0);
        chk("clr.dout",  32'(a_dout),  32'd0);

        // Simultaneous read and write
        a_op(1, 0, 0, 8'd1); a_op(1, 0, 0, 8'd2); a_op(1, 0, 0, 8'd3);
        a_op(1, 1, 0, 8'd9);
        chk("sim.full.count", 32'(a_count), 32'd3);
        chk("sim.full.dout",  32'(a_dout),  32'd1);
        chk("sim.full.ovf",   32'(a_ovf),   32'd0);
        a_op(0, 1, 0, 8'd0); chk("sim.d0", 32'(a_dout), 32'd2);
        a_op(0, 1, 0, 8'd0); chk("sim.d1", 32'(a_dout), 32'd3);
        a_op(0, 1, 0, 8'd0); chk("sim.d2", 32'(a_dout), 32'd9);
        a_op(1, 1, 0, 8'h44);
        chk("sim.empty.count", 32'(a_count), 32'd1);
        chk("sim.empty.unf",   32'(a_unf),   32'd1);
        a_op(0, 0, 1, 8'd0);

        // FWFT instance: fall-through, almost_full threshold, async reset
        b_op(1, 0, 0, 8'hA5);
        chk("fwft.dout", 32'(b_dout), 32'hA5);
        for (int i = 1; i < 5; i++) b_op(1, 0, 0, 8'(i));
        chk("fwft.af5", 32'(b_af), 32'd0);
        b_op(1, 0, 0, 8'h55);
        chk("fwft.count6", 32'(b_count), 32'd6);
        chk("fwft.af6",    32'(b_af),    32'd1);
        b_op(0, 1, 0, 8'd0);
        chk("fwft.pop", 32'(b_dout), 32'h01);
        a_op(1, 0, 0, 8'h77);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_a();
        check_b();
        chk("arst.b.count", 32'(b_count), 32'd0);
        chk("arst.b.af",    32'(b_af),    32'd0);
        #3 rst = 1'b1;

        // Randomized traffic with alternating fill-biased / drain-biased phases
        for (int i = 0; i < 600; i++) begin
            bit fillp;
            fillp = ((i / 40) % 2) == 0;
            a_wr  = fillp ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            a_rd  = fillp ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            a_clr = ($urandom_range(0, 60) == 0);
            a_din = 8'($urandom);
            b_wr  = fillp ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            b_rd  = fillp ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            b_clr = ($urandom_range(0, 60) == 0);
            b_din = 8'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
